// File: rtl/irq_controller.sv
// Interrupt controller: pending/mask/priority arbitration and a request/claim/complete handshake.
// Build option IRQ_TIMEOUT_EN adds an acknowledge timeout that raises the sticky irq_err flag.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | no request presented; waits for an arbitration winner
// S_REQ     | irq_out high, irq_id re-arbitrated each cycle until ack
// S_SERVICE | trap taken, irq_id held, waits for irq_complete (mret)
module irq_controller #(
   parameter int NUM_SRC     = 8,
   parameter int PRIO_W      = 3,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic               cfg_we,
   input  logic [4:0]         cfg_addr,
   input  logic [31:0]        cfg_wdata,
   output logic [31:0]        cfg_rdata,
   input  logic               trap_ack,
   input  logic               irq_complete,
   output logic               irq_out,
   output logic [3:0]         irq_id,
   output logic               irq_err
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

   state_t             r_state;
   logic [NUM_SRC-1:0] r_enable;
   logic [NUM_SRC-1:0] r_edge_sel;
   logic [NUM_SRC-1:0] r_pending;
   logic [NUM_SRC-1:0] r_sample;
   logic [PRIO_W-1:0]  r_threshold;
   logic [PRIO_W-1:0]  r_prio [NUM_SRC];
   logic               r_irq_out;
   logic [3:0]         r_irq_id;

   logic               w_wr_en, w_wr_edge, w_wr_pend, w_wr_thr, w_wr_stat, w_wr_prio;
   logic               w_claim;
   logic [NUM_SRC-1:0] w_set, w_clr, w_cand;
   logic               w_valid;
   logic [3:0]         w_win;
   logic [PRIO_W-1:0]  w_best;
   logic [PRIO_W-1:0]  w_cur_prio;
   logic               w_cur_cand;
   logic               w_err;
   logic               w_unused;

   assign w_unused  = ^cfg_wdata;
   assign w_wr_en   = cfg_we && (cfg_addr == 5'h00);
   assign w_wr_edge = cfg_we && (cfg_addr == 5'h01);
   assign w_wr_pend = cfg_we && (cfg_addr == 5'h02);
   assign w_wr_thr  = cfg_we && (cfg_addr == 5'h03);
   assign w_wr_stat = cfg_we && (cfg_addr == 5'h04);
   assign w_wr_prio = cfg_we && cfg_addr[4] && ({28'd0, cfg_addr[3:0]} < 32'(NUM_SRC));
   assign w_claim   = (r_state == S_REQ) && trap_ack;

   always_comb begin
      w_set = '0;
      w_clr = '0;
      w_cand = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         w_set[i]  = irq_src[i] && (!r_edge_sel[i] || !r_sample[i]);
         w_clr[i]  = (w_wr_pend && cfg_wdata[i]) || (w_claim && (r_irq_id == 4'(i)));
         w_cand[i] = r_pending[i] && r_enable[i] && (r_prio[i] > r_threshold);
      end
   end

   // Strict '>' keeps the lowest index on priority ties.
   always_comb begin
      w_valid    = 1'b0;
      w_win      = '0;
      w_best     = '0;
      w_cur_prio = '0;
      w_cur_cand = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (w_cand[i] && (!w_valid || (r_prio[i] > w_best))) begin
            w_valid = 1'b1;
            w_win   = 4'(i);
            w_best  = r_prio[i];
         end
         if (r_irq_id == 4'(i)) begin
            w_cur_prio = r_prio[i];
            w_cur_cand = w_cand[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_enable    <= '0;
         r_edge_sel  <= '0;
         r_pending   <= '0;
         r_sample    <= '0;
         r_threshold <= '0;
         for (int i = 0; i < NUM_SRC; i++) r_prio[i] <= '0;
      end else begin
         r_sample  <= irq_src;
         r_pending <= (r_pending & ~w_clr) | w_set;
         if (w_wr_en)   r_enable    <= cfg_wdata[NUM_SRC-1:0];
         if (w_wr_edge) r_edge_sel  <= cfg_wdata[NUM_SRC-1:0];
         if (w_wr_thr)  r_threshold <= cfg_wdata[PRIO_W-1:0];
         for (int i = 0; i < NUM_SRC; i++)
            if (w_wr_prio && (cfg_addr[3:0] == 4'(i))) r_prio[i] <= cfg_wdata[PRIO_W-1:0];
      end
   end

`ifdef IRQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] r_to_cnt;
   logic             r_err;
   assign w_err = r_err;
`else
   assign w_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_irq_out <= 1'b0;
         r_irq_id  <= '0;
`ifdef IRQ_TIMEOUT_EN
         r_to_cnt  <= '0;
         r_err     <= 1'b0;
`endif
      end else begin
`ifdef IRQ_TIMEOUT_EN
         if (w_wr_stat && cfg_wdata[31]) r_err <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               r_irq_out <= 1'b0;
               if (w_valid) begin
                  r_irq_id  <= w_win;
                  r_state   <= S_REQ;
                  r_irq_out <= 1'b1;
`ifdef IRQ_TIMEOUT_EN
                  r_to_cnt  <= CNT_W'(TIMEOUT_CYC - 1);
`endif
               end
            end
            S_REQ: begin
               if (trap_ack) begin
                  r_state   <= S_SERVICE;
                  r_irq_out <= 1'b0;
               end
`ifdef IRQ_TIMEOUT_EN
               else if (r_to_cnt == '0) begin
                  r_state   <= S_IDLE;
                  r_irq_out <= 1'b0;
                  r_err     <= 1'b1;
               end
`endif
               else if (!w_valid) begin
                  r_state   <= S_IDLE;
                  r_irq_out <= 1'b0;
               end else if (!w_cur_cand || (w_best > w_cur_prio)) begin
                  r_irq_id <= w_win;
               end
`ifdef IRQ_TIMEOUT_EN
               r_to_cnt <= r_to_cnt - 1'b1;
`endif
            end
            S_SERVICE: begin
               r_irq_out <= 1'b0;
               if (irq_complete) r_state <= S_IDLE;
            end
            default: begin
               r_state   <= S_IDLE;
               r_irq_out <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      cfg_rdata = '0;
      case (cfg_addr)
         5'h00:   cfg_rdata[NUM_SRC-1:0] = r_enable;
         5'h01:   cfg_rdata[NUM_SRC-1:0] = r_edge_sel;
         5'h02:   cfg_rdata[NUM_SRC-1:0] = r_pending;
         5'h03:   cfg_rdata[PRIO_W-1:0]  = r_threshold;
         5'h04:   cfg_rdata = {w_err, 22'd0, (r_state == S_SERVICE), 4'd0, r_irq_id};
         default: begin
            for (int i = 0; i < NUM_SRC; i++)
               if (cfg_addr[4] && (cfg_addr[3:0] == 4'(i))) cfg_rdata[PRIO_W-1:0] = r_prio[i];
         end
      endcase
   end

   assign irq_out = r_irq_out;
   assign irq_id  = r_irq_id;
   assign irq_err = w_err;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: expectations queued with the stimulus, popped at each check.
module tb_irq_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  irq_src = '0;
   logic        cfg_we = 1'b0;
   logic [4:0]  cfg_addr = '0;
   logic [31:0] cfg_wdata = '0;
   logic [31:0] cfg_rdata;
   logic        trap_ack = 1'b0;
   logic        irq_complete = 1'b0;
   logic        irq_out;
   logic [3:0]  irq_id;
   logic        irq_err;

   int n_cmp = 0;
   int n_mis = 0;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;
   exp_t sb[$];

   irq_controller #(.NUM_SRC(8), .PRIO_W(3), .TIMEOUT_CYC(64)) dut (
      .clk(clk), .rst(rst), .irq_src(irq_src),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
      .trap_ack(trap_ack), .irq_complete(irq_complete),
      .irq_out(irq_out), .irq_id(irq_id), .irq_err(irq_err)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic ex(input string tag, input logic [31:0] v);
      sb.push_back('{tag, v});
   endtask

   task automatic cmp(input logic [31:0] obs);
      exp_t e;
      n_cmp++;
      if (sb.size() == 0) begin
         n_mis++;
         $display("FAIL scoreboard_empty observed=%0h", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      cfg_we = 1'b1;
      cfg_addr = a;
      cfg_wdata = d;
      step(1);
      cfg_we = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      cfg_addr = a;
      #1;
      d = cfg_rdata;
   endtask

   task automatic pulse_ack();
      trap_ack = 1'b1;
      step(1);
      trap_ack = 1'b0;
   endtask

   task automatic pulse_cpl();
      irq_complete = 1'b1;
      step(1);
      irq_complete = 1'b0;
   endtask

   initial begin
      logic [31:0] d;

      // reset state
      step(2);
      ex("rst_irq_out", 0); cmp(32'(irq_out));
      ex("rst_irq_id", 0);  cmp(32'(irq_id));
      ex("rst_irq_err", 0); cmp(32'(irq_err));
      rd(5'h04, d); ex("rst_status", 0); cmp(d);
      rst = 1'b0;
      step(1);

      // level request on source 2
      wr(5'h12, 3); wr(5'h03, 1); wr(5'h00, 32'h04);
      rd(5'h00, d); ex("enable_rd", 32'h04); cmp(d);
      irq_src = 8'h04;
      ex("lvl_pend", 32'h04); ex("lvl_out_early", 0);
      step(1);
      rd(5'h02, d); cmp(d); cmp(32'(irq_out));
      ex("lvl_out", 1); ex("lvl_id", 2);
      step(1);
      cmp(32'(irq_out)); cmp(32'(irq_id));
      irq_src = 8'h00;
      ex("lvl_ack_out", 0); ex("lvl_ack_status", 32'h102); ex("lvl_ack_pend", 0);
      pulse_ack();
      cmp(32'(irq_out)); rd(5'h04, d); cmp(d); rd(5'h02, d); cmp(d);
      ex("lvl_cpl_status", 32'h002); ex("lvl_idle_out", 0);
      pulse_cpl();
      rd(5'h04, d); cmp(d);
      step(2);
      cmp(32'(irq_out));

      // priority and tie-break among sources 1, 5, 6
      wr(5'h11, 4); wr(5'h15, 4); wr(5'h16, 6); wr(5'h00, 32'h62);
      irq_src = 8'h62;
      step(1);
      irq_src = 8'h00;
      ex("prio_out", 1); ex("prio_id6", 6);
      step(1);
      cmp(32'(irq_out)); cmp(32'(irq_id));
      pulse_ack();
      ex("prio_pend_after_claim", 32'h22);
      rd(5'h02, d); cmp(d);
      pulse_cpl();
      ex("tie_out", 1); ex("tie_id1", 1);
      step(1);
      cmp(32'(irq_out)); cmp(32'(irq_id));
      pulse_ack();
      pulse_cpl();
      ex("next_id5", 5);
      step(1);
      cmp(32'(irq_id));

      // withdrawal by disabling while in REQ
      ex("wd_out_same", 1); ex("wd_out_next", 0);
      wr(5'h00, 0);
      cmp(32'(irq_out));
      step(1);
      cmp(32'(irq_out));
      ex("wd_ack_out", 0); ex("wd_ack_status", 32'h005); ex("wd_pend", 32'h20);
      pulse_ack();
      cmp(32'(irq_out)); rd(5'h04, d); cmp(d); rd(5'h02, d); cmp(d);
      ex("w1c_pend", 0);
      wr(5'h02, 32'h20);
      rd(5'h02, d); cmp(d);

      // edge source: new edge in the claim cycle keeps pending set
      wr(5'h01, 32'h08); wr(5'h13, 5); wr(5'h00, 32'h08);
      irq_src = 8'h08;
      step(1);
      ex("edge_id3", 3); ex("edge_out", 1);
      step(1);
      cmp(32'(irq_id)); cmp(32'(irq_out));
      irq_src = 8'h00;
      step(1);
      irq_src = 8'h08;
      ex("edge_sim_pend", 32'h08); ex("edge_sim_status", 32'h103); ex("edge_sim_out", 0);
      pulse_ack();
      rd(5'h02, d); cmp(d); rd(5'h04, d); cmp(d); cmp(32'(irq_out));
      pulse_cpl();
      ex("edge_rereq_out", 1); ex("edge_rereq_id", 3);
      step(1);
      cmp(32'(irq_out)); cmp(32'(irq_id));
      ex("edge_held_no_repend", 0);
      pulse_ack();
      rd(5'h02, d); cmp(d);
      pulse_cpl();
      irq_src = 8'h00;
      wr(5'h01, 0);

      // prio 0 and prio == threshold never request
      wr(5'h00, 32'h01);
      irq_src = 8'h01;
      step(5);
      ex("prio0_out", 0); cmp(32'(irq_out));
      wr(5'h10, 1);
      step(3);
      ex("prio_eq_thr_out", 0); cmp(32'(irq_out));
      wr(5'h10, 2);
      ex("prio_raise_out", 1); ex("prio_raise_id", 0);
      step(1);
      cmp(32'(irq_out)); cmp(32'(irq_id));
      rd(5'h05, d); ex("unmapped_05", 0); cmp(d);
      rd(5'h18, d); ex("unmapped_18", 0); cmp(d);
      rd(5'h10, d); ex("prio0_rd", 2); cmp(d);

`ifdef IRQ_TIMEOUT_EN
      step(63);
      ex("to_before_out", 1); ex("to_before_err", 0);
      cmp(32'(irq_out)); cmp(32'(irq_err));
      step(1);
      ex("to_out", 0); ex("to_err", 1); ex("to_status", 32'h8000_0000);
      cmp(32'(irq_out)); cmp(32'(irq_err)); rd(5'h04, d); cmp(d);
      step(1);
      ex("to_rereq_out", 1); cmp(32'(irq_out));
      wr(5'h04, 32'h8000_0000);
      ex("to_err_clr", 0); cmp(32'(irq_err));
`else
      step(100);
      ex("noto_out_held", 1); ex("noto_err", 0);
      cmp(32'(irq_out)); cmp(32'(irq_err));
`endif

      // threshold raise withdraws, lowering re-requests
      wr(5'h03, 7);
      ex("thr_out", 0);
      step(1);
      cmp(32'(irq_out));
      wr(5'h03, 1);
      ex("thr_rereq_out", 1);
      step(1);
      cmp(32'(irq_out));

      // reset mid-REQ clears immediately
      #2;
      rst = 1'b1;
      #1;
      ex("mrst_out", 0); ex("mrst_id", 0); ex("mrst_err", 0);
      ex("mrst_status", 0); ex("mrst_enable", 0); ex("mrst_pend", 0);
      cmp(32'(irq_out)); cmp(32'(irq_id)); cmp(32'(irq_err));
      rd(5'h04, d); cmp(d); rd(5'h00, d); cmp(d); rd(5'h02, d); cmp(d);
      irq_src = 8'h00;
      step(2);
      rst = 1'b0;
      step(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
